// File: rtl/ternary_pkg.sv
// Shared encodings, op codes, FSM states and trit decode for the serial ternary ALU.
// Optional invalid-code checking in the top is enabled by TERNARY_INVALID_CHECK_EN.
package ternary_pkg;

   localparam logic [1:0] T0    = 2'b00;
   localparam logic [1:0] T1    = 2'b01;
   localparam logic [1:0] T2    = 2'b10;
   localparam logic [1:0] T_INV = 2'b11;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MIN = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Invalid code reads as zero so arithmetic never sees it.
   function automatic logic [1:0] trit_dec(input logic [1:0] t);
      unique case (t)
         T0:      trit_dec = 2'd0;
         T1:      trit_dec = 2'd1;
         T2:      trit_dec = 2'd2;
         T_INV:   trit_dec = 2'd0;
         default: trit_dec = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/ternary_serial_alu_full_adder.sv
// Single-trit unbalanced-ternary full adder.
// Carry in/out are trit codes (T0 or T1).
module ternary_full_adder
   import ternary_pkg::*;
(
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic [1:0] cin,
   output logic [1:0] digit,
   output logic [1:0] cout
);

   logic [2:0] s;

   // Sum of decoded trits, reduced mod 3 with carry.
   always_comb begin
      s = {1'b0, trit_dec(a)} + {1'b0, trit_dec(b)} + {1'b0, trit_dec(cin)};
      if (s >= 3'd3) begin
         digit = 2'(s - 3'd3);
         cout  = T1;
      end else begin
         digit = s[1:0];
         cout  = T0;
      end
   end

endmodule

// File: rtl/ternary_serial_alu.sv
// Serial ternary ALU: ADD or trit-wise MIN, one trit per clock, LSB first.
// Define TERNARY_INVALID_CHECK_EN to add the error port and invalid-code check.
module ternary_serial_alu
   import ternary_pkg::*;
#(
   parameter int NTRITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                op,
   input  logic [2*NTRITS-1:0] a,
   input  logic [2*NTRITS-1:0] b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*NTRITS-1:0] result,
   output logic [1:0]          carry_out
`ifdef TERNARY_INVALID_CHECK_EN
   ,output logic               error
`endif
);

   localparam int W  = 2 * NTRITS;
   localparam int IW = (NTRITS > 1) ? $clog2(NTRITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NTRITS - 1);

   state_e        state;
   logic [IW-1:0] idx;
   logic [1:0]    c;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          op_q;

   logic [1:0] a_t;
   logic [1:0] b_t;
   logic [1:0] a_v;
   logic [1:0] b_v;
   logic [1:0] min_d;
   logic [1:0] fa_digit;
   logic [1:0] fa_cout;
   logic [1:0] digit;
   logic [1:0] c_next;

`ifdef TERNARY_INVALID_CHECK_EN
   function automatic logic has_inv(input logic [W-1:0] v);
      has_inv = 1'b0;
      for (int i = 0; i < NTRITS; i++)
         if (v[2*i +: 2] == T_INV)
            has_inv = 1'b1;
   endfunction
`endif

   ternary_full_adder u_fa (
      .a     (a_t),
      .b     (b_t),
      .cin   (c),
      .digit (fa_digit),
      .cout  (fa_cout)
   );

   // Select the current trit pair and form the next digit and carry.
   always_comb begin
      a_t   = a_q[{idx, 1'b0} +: 2];
      b_t   = b_q[{idx, 1'b0} +: 2];
      a_v   = trit_dec(a_t);
      b_v   = trit_dec(b_t);
      min_d = (a_v < b_v) ? a_v : b_v;
      if (op_q == OP_MIN) begin
         digit  = min_d;
         c_next = T0;
      end else begin
         digit  = fa_digit;
         c_next = fa_cout;
      end
   end

   // Control FSM with registered handshake outputs and result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         carry_out <= T0;
         idx       <= '0;
         c         <= T0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_ADD;
`ifdef TERNARY_INVALID_CHECK_EN
         error     <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  a_q      <= a;
                  b_q      <= b;
                  op_q     <= op;
                  idx      <= '0;
                  c        <= T0;
                  in_ready <= 1'b0;
                  state    <= RUN;
`ifdef TERNARY_INVALID_CHECK_EN
                  error    <= has_inv(a) | has_inv(b);
`endif
               end
            end
            RUN: begin
               result[{idx, 1'b0} +: 2] <= digit;
               c   <= c_next;
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  carry_out <= c_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ternary_serial_alu.sv
// Scoreboard bench for ternary_serial_alu at NTRITS=4.
// Directed vectors; a negedge monitor pops expected results on each output handshake.
module tb_ternary_serial_alu;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         op;
   logic [2*N-1:0] a;
   logic [2*N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [2*N-1:0] result;
   logic [1:0]   carry_out;
`ifdef TERNARY_INVALID_CHECK_EN
   logic         error;
`endif

   typedef struct packed {
      logic [2*N-1:0] r;
      logic [1:0]     c;
      logic           e;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   ternary_serial_alu #(.NTRITS(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out)
`ifdef TERNARY_INVALID_CHECK_EN
      ,.error    (error)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: compare against the scoreboard on every output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_output", 32'(out_valid), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("sb_result", 32'(result), 32'(e.r));
               chk("sb_carry", 32'(carry_out), 32'(e.c));
`ifdef TERNARY_INVALID_CHECK_EN
               chk("sb_error", 32'(error), 32'(e.e));
`endif
            end
         end
      end
   end

   task automatic run_op(input string nm, input logic [2*N-1:0] av,
                         input logic [2*N-1:0] bv, input logic o,
                         input logic [2*N-1:0] er, input logic [1:0] ec,
                         input logic ee);
      int k;
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      a = av;
      b = bv;
      op = o;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = '1;
      b = '1;
      op = ~o;
      sbq.push_back('{r: er, c: ec, e: ee});
      k = 0;
      while (out_valid !== 1'b1 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({nm, "_latency"}, 32'(k), 32'd4);
      if (out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int bad;
      rst_n = 1'b0;
      in_valid = 1'b0;
      op = 1'b0;
      a = '0;
      b = '0;
      out_ready = 1'b1;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_carry", 32'(carry_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_release_in_ready", 32'(in_ready), 32'd1);

      run_op("add_basic", 8'b10_01_00_10, 8'b01_10_10_01, 1'b0,
             8'b01_01_00_00, 2'b01, 1'b0);
      run_op("min_basic", 8'b10_01_00_10, 8'b01_10_10_01, 1'b1,
             8'b01_01_00_01, 2'b00, 1'b0);
      run_op("add_wrap", 8'b10_10_10_10, 8'b10_10_10_10, 1'b0,
             8'b10_10_10_01, 2'b01, 1'b0);
      run_op("add_zero", 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0);
      run_op("add_chain", 8'b00_00_00_10, 8'b00_00_00_01, 1'b0,
             8'b00_00_01_00, 2'b00, 1'b0);
`ifdef TERNARY_INVALID_CHECK_EN
      run_op("add_invalid", 8'b00_11_00_01, 8'b00_00_00_01, 1'b0,
             8'b00_00_00_10, 2'b00, 1'b1);
`else
      run_op("add_invalid", 8'b00_11_00_01, 8'b00_00_00_01, 1'b0,
             8'b00_00_00_10, 2'b00, 1'b0);
`endif
      run_op("min_after_inv", 8'b10_00_01_10, 8'b01_10_10_00, 1'b1,
             8'b01_00_01_00, 2'b00, 1'b0);

      // Backpressure in DONE with a stray in_valid pulse.
      out_ready = 1'b0;
      run_op("bp_min", 8'b10_01_00_10, 8'b01_10_10_01, 1'b1,
             8'b01_01_00_01, 2'b00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            in_valid = 1'b1;
            a = 8'h55;
            b = 8'h55;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_result", 32'(result), 32'(8'b01_01_00_01));
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) bad++;
      end
      chk("bp_stray_ignored", 32'(bad), 32'd0);

      // Reset in the middle of RUN at idx 2.
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      a = 8'b10_10_10_10;
      b = 8'b10_10_10_10;
      op = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_result", 32'(result), 32'd0);
      chk("mid_rst_carry", 32'(carry_out), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mid_rst_hold_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_release_in_ready", 32'(in_ready), 32'd1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) bad++;
      end
      chk("mid_rst_no_output", 32'(bad), 32'd0);
      run_op("post_rst_add", 8'b00_00_00_01, 8'b00_00_00_01, 1'b0,
             8'b00_00_00_10, 2'b00, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
